// File: rtl/stopwatch_fnd_pkg.sv
// rtl/stopwatch_fnd_pkg.sv - shared constants and types for the stopwatch FND scanner
// Segment patterns are active-low: [7]=dp, [6:0]=gfedcba.
package stopwatch_fnd_pkg;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] SEG_DASH    = 8'hBF;
   localparam logic [7:0] SEG_DP_ON   = 8'h7F;
   localparam logic [3:0] COM_ALL_OFF = 4'b1111;

   localparam logic [6:0] MSEC_MAX = 7'd99;
   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   localparam logic [6:0] DP_MSEC_LIMIT = 7'd50;

   typedef logic [1:0] digit_idx_t;

   typedef struct packed {
      logic       sel_mode;
      logic [6:0] msec;
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hour;
   } snap_t;

   // Active-low one-hot digit enable for the given index.
   function automatic logic [3:0] com_sel(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// rtl/fnd_seg_decoder.sv - BCD to active-low gfedcba segment decoder
// Codes 10..15 produce a blank pattern.
module fnd_seg_decoder (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      case (i_bcd)
         4'd0:    o_seg = 7'h40;
         4'd1:    o_seg = 7'h79;
         4'd2:    o_seg = 7'h24;
         4'd3:    o_seg = 7'h30;
         4'd4:    o_seg = 7'h19;
         4'd5:    o_seg = 7'h12;
         4'd6:    o_seg = 7'h02;
         4'd7:    o_seg = 7'h78;
         4'd8:    o_seg = 7'h00;
         4'd9:    o_seg = 7'h10;
         default: o_seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// rtl/stopwatch_fnd_ctrl.sv - 4-digit FND scanner for the stopwatch time fields
// Optional FND_LEADING_ZERO_BLANK_EN blanks a zero in the leftmost digit.
module stopwatch_fnd_ctrl
   import stopwatch_fnd_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SCAN_HZ  = 1_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_sel_mode,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   output logic [3:0] o_fnd_com,
   output logic [7:0] o_fnd_data
);

   localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
   localparam int CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;
   snap_t            snap_q, snap_d;
   logic [3:0]       com_q, com_d;
   logic [7:0]       data_q, data_d;

   logic       scan_tick;
   logic [6:0] hi_val, lo_val;
   logic [6:0] hi_tens, hi_ones, lo_tens, lo_ones;
   logic       hi_bad, lo_bad;
   logic [3:0] digit_val;
   logic       digit_bad;
   logic [6:0] digit_seg;
   logic [7:0] digit_data;

   fnd_seg_decoder u_seg_decoder (
      .i_bcd (digit_val),
      .o_seg (digit_seg)
   );

   always_comb begin
      scan_tick = (cnt_q == CNT_LAST);
      cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      snap_d    = snap_q;
      if (scan_tick) begin
         idx_d = idx_q + 2'd1;
         if (idx_d == 2'd0) begin
            snap_d.sel_mode = i_sel_mode;
            snap_d.msec     = msec;
            snap_d.sec      = sec;
            snap_d.min      = min;
            snap_d.hour     = hour;
         end
      end
   end

   // The digit shown after a tick is derived from the post-tick index and snapshot.
   always_comb begin
      hi_val  = snap_d.sel_mode ? {2'b00, snap_d.hour} : {1'b0, snap_d.sec};
      lo_val  = snap_d.sel_mode ? {1'b0, snap_d.min}   : snap_d.msec;
      hi_bad  = snap_d.sel_mode ? (snap_d.hour > HOUR_MAX) : (snap_d.sec > SEC_MAX);
      lo_bad  = snap_d.sel_mode ? (snap_d.min > MIN_MAX)   : (snap_d.msec > MSEC_MAX);
      hi_tens = hi_val / 7'd10;
      hi_ones = hi_val % 7'd10;
      lo_tens = lo_val / 7'd10;
      lo_ones = lo_val % 7'd10;

      digit_val = lo_ones[3:0];
      digit_bad = lo_bad;
      case (idx_d)
         2'd0: begin digit_val = lo_ones[3:0]; digit_bad = lo_bad; end
         2'd1: begin digit_val = lo_tens[3:0]; digit_bad = lo_bad; end
         2'd2: begin digit_val = hi_ones[3:0]; digit_bad = hi_bad; end
         default: begin digit_val = hi_tens[3:0]; digit_bad = hi_bad; end
      endcase

      digit_data = {1'b1, digit_seg};
      if (idx_d == 2'd2 && snap_d.msec < DP_MSEC_LIMIT) begin
         digit_data = digit_data & SEG_DP_ON;
      end
      if (digit_bad) begin
         digit_data = SEG_DASH;
      end
`ifdef FND_LEADING_ZERO_BLANK_EN
      else if (idx_d == 2'd3 && digit_val == 4'd0) begin
         digit_data = SEG_BLANK;
      end
`else
      else begin
         digit_data = digit_data;
      end
`endif

      com_d  = com_q;
      data_d = data_q;
      if (scan_tick) begin
         com_d  = com_sel(idx_d);
         data_d = digit_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= 2'd3;
         snap_q <= '0;
         com_q  <= COM_ALL_OFF;
         data_q <= SEG_BLANK;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         com_q  <= com_d;
         data_q <= data_d;
      end
   end

   assign o_fnd_com  = com_q;
   assign o_fnd_data = data_q;

endmodule

// File: tb/tb_stopwatch_fnd_ctrl.sv
// tb/tb_stopwatch_fnd_ctrl.sv - self-checking bench for stopwatch_fnd_ctrl
// Reference model tracks elapsed cycles and frame snapshots arithmetically.
module tb_stopwatch_fnd_ctrl;

   localparam int CLK_FREQ = 4000;
   localparam int SCAN_HZ  = 1000;
   localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [3:0] com;
   logic [7:0] data;

   int n_vec = 0;
   int n_err = 0;

   int         k;
   int         m_sel, m_msec, m_sec, m_min, m_hour;
   logic [3:0] e_com;
   logic [7:0] e_data;

   stopwatch_fnd_ctrl #(
      .CLK_FREQ (CLK_FREQ),
      .SCAN_HZ  (SCAN_HZ)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_sel_mode (sel),
      .msec       (msec),
      .sec        (sec),
      .min        (min),
      .hour       (hour),
      .o_fnd_com  (com),
      .o_fnd_data (data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: com/data got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] seg7(input int d);
      logic [6:0] tbl [0:9];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      if (d < 0 || d > 9) return 8'hFF;
      return {1'b1, tbl[d]};
   endfunction

   function automatic logic [7:0] exp_digit(input int idx);
      int         hi, lo, v;
      bit         hi_bad, lo_bad, bad;
      logic [7:0] r;
      hi     = m_sel ? m_hour : m_sec;
      lo     = m_sel ? m_min  : m_msec;
      hi_bad = m_sel ? (m_hour > 23) : (m_sec > 59);
      lo_bad = m_sel ? (m_min > 59)  : (m_msec > 99);
      case (idx)
         0:       begin v = lo % 10; bad = lo_bad; end
         1:       begin v = lo / 10; bad = lo_bad; end
         2:       begin v = hi % 10; bad = hi_bad; end
         default: begin v = hi / 10; bad = hi_bad; end
      endcase
      if (bad) return 8'hBF;
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (idx == 3 && v == 0) return 8'hFF;
`endif
      r = seg7(v);
      if (idx == 2 && m_msec < 50) r[7] = 1'b0;
      return r;
   endfunction

   // Called right after each rising edge with the inputs the DUT just sampled.
   task automatic model_step();
      int idx;
      if (rst) begin
         k = 0;
         m_sel = 0; m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0;
         e_com  = 4'b1111;
         e_data = 8'hFF;
      end else begin
         k++;
         if (k % SCAN_DIV == 0) begin
            idx = (k / SCAN_DIV - 1) % 4;
            if (idx == 0) begin
               m_sel  = int'(sel);
               m_msec = int'(msec);
               m_sec  = int'(sec);
               m_min  = int'(min);
               m_hour = int'(hour);
            end
            e_com  = ~(4'b0001 << idx);
            e_data = exp_digit(idx);
         end
      end
   endtask

   task automatic step(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk(tag, {com, data}, {e_com, e_data});
      end
   endtask

   task automatic rand_change();
      case ($urandom_range(0, 4))
         0: msec = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
         1: sec  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63))   : 6'($urandom_range(0, 59));
         2: min  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63))   : 6'($urandom_range(0, 59));
         3: hour = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31))   : 5'($urandom_range(0, 23));
         default: sel = ~sel;
      endcase
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; msec = '0; sec = '0; min = '0; hour = '0;
      k = 0; e_com = 4'b1111; e_data = 8'hFF;
      m_sel = 0; m_msec = 0; m_sec = 0; m_min = 0; m_hour = 0;
      @(negedge clk);
      step("reset", 3);

      rst = 1'b0; sel = 1'b0; sec = 6'd12; msec = 7'd34;
      step("ss_mm", 20);

      sel = 1'b1; hour = 5'd23; min = 6'd5; msec = 7'd0;
      step("hh_mm", 16);

      sel = 1'b0; sec = 6'd12; msec = 7'd70;
      step("mid_frame_pre", 10);
      sec = 6'd13;
      step("mid_frame_post", 14);

      msec = 7'd120;
      step("msec_dash", 16);
      msec = 7'd40; sec = 6'd60;
      step("sec_dash", 16);

      sec = 6'd5; msec = 7'd7;
      step("lead_zero", 16);

      step("pre_rst", 6);
      rst = 1'b1;
      step("rst_mid", 1);
      rst = 1'b0;
      step("post_rst", 10);

      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) rand_change();
         rst = ($urandom_range(0, 79) == 0);
         step("random", 1);
      end
      rst = 1'b0;
      step("tail", 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
